axis_frame_stamper: RTL and testbench
=====================================

Name: axis_frame_stamper

Overview:
- AXI-Stream stage between the test stream generator and the AXI DMA S2MM slave port, in the axi_aclk domain.
- Prepends a 2-word header (sync/sequence word, length word) to every frame.
- Enforces the software-programmed frame_size on the payload so the DMA always receives well-formed frames:
  - short frames are closed early and flagged;
  - long frames are truncated and the excess upstream beats discarded.

Parameters:
- SYNC_WORD, 16'hA5A5: upper half of header word 0.
- SEQ_W, 16: width of the frame sequence counter. Must be ≤ 16.
- CNT_W, 16: width of each error counter. Counters saturate at the maximum value.

Ports:
- clk, input, 1: axi_aclk.
- reset, input, 1: synchronous, active-high.
- frame_size, input, 32: payload beats per frame. Sampled at frame start.
- s_tdata, input, 32: upstream data.
- s_tkeep, input, 4: upstream byte keep.
- s_tlast, input, 1: upstream end of frame.
- s_tvalid, input, 1: upstream valid.
- s_tready, output, 1: upstream ready.
- m_tdata, output, 32: data to DMA.
- m_tkeep, output, 4: byte keep to DMA.
- m_tlast, output, 1: end of frame to DMA.
- m_tvalid, output, 1: valid to DMA.
- m_tready, input, 1: DMA ready.
- seq_num, output, SEQ_W: sequence number of the next frame to be stamped.
- err_short, output, CNT_W: count of frames with upstream tlast before frame_size beats.
- err_long, output, CNT_W: count of frames truncated at frame_size.

Behaviour:
- Single clock (clk). Synchronous active-high reset.
- Reset values:
  - state = IDLE;
  - m_tvalid = 0, m_tdata = 0, m_tkeep = 0, m_tlast = 0;
  - s_tready = 0;
  - seq_num = 0, err_short = 0, err_long = 0.
- Output register:
  - m_* are registered.
  - The register loads when !m_tvalid || m_tready ("adv").
  - m_tvalid clears on m_tready when nothing new loads.
  - m_tdata/m_tkeep/m_tlast hold while m_tvalid && !m_tready.
- FSM states:
  - IDLE:
    - s_tready = 0.
    - On s_tvalid, latch fs = (frame_size == 0) ? 1 : frame_size, clear beat_cnt, go HDR0. The upstream beat is not consumed.
  - HDR0:
    - s_tready = 0.
    - On adv, load m_tdata = {SYNC_WORD, zero-extended seq_num}, m_tkeep = 4'hF, m_tlast = 0; go HDR1.
  - HDR1:
    - s_tready = 0.
    - On adv, load m_tdata = fs, m_tkeep = 4'hF, m_tlast = 0; go PAYLOAD.
  - PAYLOAD:
    - s_tready = adv (combinational).
    - On each accepted beat: pass s_tdata/s_tkeep and increment beat_cnt.
    - Last beat condition: m_tlast = s_tlast || (beat_cnt == fs-1).
    - s_tlast with beat_cnt < fs-1: err_short++ (saturating); seq_num++; go IDLE.
    - beat_cnt == fs-1 with s_tlast: normal frame; seq_num++; go IDLE.
    - beat_cnt == fs-1 without s_tlast: err_long++ (saturating); seq_num++; go DISCARD.
  - DISCARD:
    - s_tready = 1. Nothing is forwarded.
    - On an accepted s_tlast, go IDLE.
- Latency: one cycle from s_tvalid&&s_tready to m_tvalid. Two header beats are added per frame.
- Throughput: one beat per clock when m_tready is held high. No bubble between header and payload.
- frame_size changes mid-frame have no effect until the next IDLE→HDR0 transition.
- seq_num wraps from 2^SEQ_W-1 to 0.
- Reset mid-frame:
  - state returns to IDLE;
  - any pending m_tvalid is dropped;
  - counters clear;
  - the remainder of the upstream frame is treated as a new frame on the next s_tvalid.
- beat_cnt is 32 bits and compares against fs-1 without overflow for fs up to 2^32-1.

Optional Feature:
- Macro: AXIS_FRAME_STAMPER_TRAILER_EN.
- When defined:
  - The payload's final beat is emitted with m_tlast = 0.
  - A TRAILER state follows, loading one extra beat on adv: m_tdata = XOR of all forwarded payload s_tdata words in the frame, m_tkeep = 4'hF, m_tlast = 1.
  - For a long frame, the TRAILER beat is emitted before DISCARD.
  - The XOR accumulator clears at HDR0.
- When undefined: no TRAILER state, no accumulator; m_tlast goes on the final payload beat as above.

Test Plan:
- Normal frame, zero backpressure:
  - Stimulus: reset, frame_size = 4, upstream words 1,2,3,4 with tlast on 4, m_tready = 1.
  - Response: output 0xA5A50000, 4, 1, 2, 3, 4 with tlast on 4 only; seq_num = 1; errors = 0.
- Short frame:
  - Stimulus: frame_size = 8, upstream 3 beats with tlast on the 3rd.
  - Response: 5 output beats, tlast on the 5th; err_short = 1; header word 0 = 0xA5A50001 on the next frame.
- Long frame:
  - Stimulus: frame_size = 3, upstream 6 beats with tlast on the 6th.
  - Response: header + 3 payload beats, tlast on payload beat 3; beats 4–6 accepted and dropped (s_tready = 1); err_long = 1; state returns to IDLE.
- Backpressure:
  - Stimulus: frame_size = 16, m_tready toggling 1010….
  - Response: no beat lost or duplicated; m_tdata stable while m_tvalid && !m_tready; payload order preserved.
- Edge cases:
  - frame_size = 0 behaves as 1: one payload beat with tlast.
  - 65536 frames: seq_num wraps to 0.
  - Reset asserted during payload beat 2: m_tvalid = 0 the next cycle and all counters = 0.
- Trailer (AXIS_FRAME_STAMPER_TRAILER_EN defined):
  - Stimulus: frame_size = 2, words 0x0F0F0F0F and 0xFFFF0000.
  - Response: trailer beat = 0xF0F00F0F with tlast; the preceding payload beat has tlast = 0.

Source files
------------

// File: rtl/axis_frame_stamper.sv
// AXI-Stream framer: prepends a sync/sequence + length header and enforces frame_size on the payload.
// Optional checksum trailer beat enabled by defining AXIS_FRAME_STAMPER_TRAILER_EN.
module axis_frame_stamper #(
  parameter logic [15:0] SYNC_WORD = 16'hA5A5,
  parameter int unsigned SEQ_W     = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      frame_size,
  input  logic [31:0]      s_tdata,
  input  logic [3:0]       s_tkeep,
  input  logic             s_tlast,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [31:0]      m_tdata,
  output logic [3:0]       m_tkeep,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [SEQ_W-1:0] seq_num,
  output logic [CNT_W-1:0] err_short,
  output logic [CNT_W-1:0] err_long
);

`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, TRAILER, DISCARD} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, DISCARD} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] fs;
  logic [31:0] beat_cnt;
  logic        adv;
  logic        at_end;
  logic        load;
  logic [31:0] ld_data;
  logic [3:0]  ld_keep;
  logic        ld_last;
  logic        start;
  logic        take_beat;
  logic        bump_seq;
  logic        bump_short;
  logic        bump_long;

`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
  logic [31:0] xor_acc;
  logic        long_pend;
`endif

  assign adv    = !m_tvalid || m_tready;
  assign at_end = (beat_cnt == fs - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_tready   = 1'b0;
    load       = 1'b0;
    ld_data    = '0;
    ld_keep    = '0;
    ld_last    = 1'b0;
    start      = 1'b0;
    take_beat  = 1'b0;
    bump_seq   = 1'b0;
    bump_short = 1'b0;
    bump_long  = 1'b0;
    case (state)
      IDLE: begin
        if (s_tvalid) begin
          start     = 1'b1;
          state_nxt = HDR0;
        end
      end
      HDR0: begin
        if (adv) begin
          load      = 1'b1;
          ld_data   = {SYNC_WORD, 16'(seq_num)};
          ld_keep   = 4'hF;
          state_nxt = HDR1;
        end
      end
      HDR1: begin
        if (adv) begin
          load      = 1'b1;
          ld_data   = fs;
          ld_keep   = 4'hF;
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        s_tready = adv;
        if (s_tvalid && adv) begin
          load      = 1'b1;
          ld_data   = s_tdata;
          ld_keep   = s_tkeep;
          take_beat = 1'b1;
          if (s_tlast || at_end) begin
            bump_seq   = 1'b1;
            bump_short = s_tlast && !at_end;
            bump_long  = at_end && !s_tlast;
`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
            state_nxt  = TRAILER;
`else
            ld_last    = 1'b1;
            state_nxt  = s_tlast ? IDLE : DISCARD;
`endif
          end
        end
      end
`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
      TRAILER: begin
        if (adv) begin
          load      = 1'b1;
          ld_data   = xor_acc;
          ld_keep   = 4'hF;
          ld_last   = 1'b1;
          state_nxt = long_pend ? DISCARD : IDLE;
        end
      end
`endif
      DISCARD: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs        <= '0;
      beat_cnt  <= '0;
      seq_num   <= '0;
      err_short <= '0;
      err_long  <= '0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tkeep   <= '0;
      m_tlast   <= 1'b0;
    end else begin
      if (start) begin
        fs       <= (frame_size == '0) ? 32'd1 : frame_size;
        beat_cnt <= '0;
      end
      if (take_beat) beat_cnt <= beat_cnt + 32'd1;
      if (bump_seq) seq_num <= seq_num + 1'b1;
      if (bump_short && (err_short != '1)) err_short <= err_short + 1'b1;
      if (bump_long && (err_long != '1)) err_long <= err_long + 1'b1;
      if (load) begin
        m_tvalid <= 1'b1;
        m_tdata  <= ld_data;
        m_tkeep  <= ld_keep;
        m_tlast  <= ld_last;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
  // Accumulator includes the final payload word, so TRAILER reads it one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_acc   <= '0;
      long_pend <= 1'b0;
    end else begin
      if (state == HDR0) xor_acc <= '0;
      else if (take_beat) xor_acc <= xor_acc ^ s_tdata;
      if (bump_seq) long_pend <= bump_long;
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_stamper.sv
// Self-checking bench for axis_frame_stamper: directed literal frames plus randomized frames
// checked against a frame-level reference model.
module tb_axis_frame_stamper;
  localparam int unsigned SEQ_W = 8;
  localparam int unsigned CNT_W = 4;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic             clk;
  logic             reset;
  logic [31:0]      frame_size;
  logic [31:0]      s_tdata;
  logic [3:0]       s_tkeep;
  logic             s_tlast;
  logic             s_tvalid;
  logic             s_tready;
  logic [31:0]      m_tdata;
  logic [3:0]       m_tkeep;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [SEQ_W-1:0] seq_num;
  logic [CNT_W-1:0] err_short;
  logic [CNT_W-1:0] err_long;

  axis_frame_stamper #(.SYNC_WORD(16'hA5A5), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .frame_size(frame_size),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .seq_num(seq_num), .err_short(err_short), .err_long(err_long)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit chk_en = 0;

  beat_t       exp_q[$];
  beat_t       seen[$];
  int          seen_cyc[$];
  logic [31:0] fw[$];
  logic [3:0]  fk[$];
  logic [31:0] lit_d[$];
  logic        lit_l[$];
  int          seq_m = 0;
  int          short_m = 0;
  int          long_m = 0;

  bit          prev_stall = 0;
  logic [36:0] prev_beat = '0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      2:       m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = $urandom_range(0, 1) == 1;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string what);
    tests++;
    fails++;
    $display("FAIL timeout_%s: got no progress expected DUT response", what);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Every output handshake is checked against the model queue; stalled beats must hold.
  always @(negedge clk) begin
    if (reset || !chk_en) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", m_tvalid, 1);
        chk("stall_beat_held", {m_tdata, m_tkeep, m_tlast}, prev_beat);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %h expected no beat", m_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("m_tdata", m_tdata, e.d);
          chk("m_tkeep", m_tkeep, e.k);
          chk("m_tlast", m_tlast, e.l);
        end
        seen.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast});
        seen_cyc.push_back(cyc);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tdata, m_tkeep, m_tlast};
    end
  end

  // Frame-level reference: header, truncated payload (plus trailer), counter updates.
  task automatic model_frame(input logic [31:0] fs_in, input int n);
    longint      fe;
    int          m;
    logic [31:0] x;
    fe = (fs_in == 0) ? 1 : longint'(fs_in);
    m  = (longint'(n) < fe) ? n : int'(fe);
    x  = '0;
    exp_q.push_back('{d: {16'hA5A5, 8'h00, 8'(seq_m)}, k: 4'hF, l: 1'b0});
    exp_q.push_back('{d: 32'(fe), k: 4'hF, l: 1'b0});
    for (int i = 0; i < m; i++) begin
      x = x ^ fw[i];
`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
      exp_q.push_back('{d: fw[i], k: fk[i], l: 1'b0});
`else
      exp_q.push_back('{d: fw[i], k: fk[i], l: (i == m - 1)});
`endif
    end
`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
    exp_q.push_back('{d: x, k: 4'hF, l: 1'b1});
`endif
    if (longint'(n) < fe && short_m < (1 << CNT_W) - 1) short_m++;
    if (longint'(n) > fe && long_m < (1 << CNT_W) - 1) long_m++;
    seq_m = (seq_m + 1) % (1 << SEQ_W);
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    @(negedge clk);
    while (!s_tready) begin
      t++;
      if (t > 500) timeout_fail("accept");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] fs, input int n, input bit gaps);
    model_frame(fs, n);
    frame_size = fs;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = fw[i];
      s_tkeep  = fk[i];
      s_tlast  = (i == n - 1);
      wait_accept();
      // frame_size is only sampled at frame start; scramble it to prove that
      if (i == 0) frame_size = $urandom;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 3000) timeout_fail("drain");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string nm);
    chk({nm, "_seq_num"}, seq_num, seq_m);
    chk({nm, "_err_short"}, err_short, short_m);
    chk({nm, "_err_long"}, err_long, long_m);
  endtask

  task automatic check_seen(input string nm);
    chk({nm, "_beats"}, seen.size(), lit_d.size());
    for (int i = 0; i < lit_d.size() && i < seen.size(); i++) begin
      chk($sformatf("%s_data%0d", nm, i), seen[i].d, lit_d[i]);
      chk($sformatf("%s_last%0d", nm, i), seen[i].l, lit_l[i]);
    end
  endtask

  task automatic directed(input logic [31:0] fs, input int n);
    fk.delete();
    for (int i = 0; i < n; i++) fk.push_back(4'hF);
    seen.delete();
    seen_cyc.delete();
    send_frame(fs, n, 0);
    wait_drain();
  endtask

  initial begin
    reset = 1'b1; frame_size = '0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_s_tready", s_tready, 0);
    chk_counters("rst");
    chk("rst_seq_lit", seq_num, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1;

    // normal frame, no backpressure
    fw = '{32'd1, 32'd2, 32'd3, 32'd4};
    directed(32'd4, 4);
`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
    lit_d = '{32'hA5A50000, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4};
    lit_l = '{0, 0, 0, 0, 0, 0, 1};
`else
    lit_d = '{32'hA5A50000, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4};
    lit_l = '{0, 0, 0, 0, 0, 1};
`endif
    check_seen("normal");
    if (seen_cyc.size() >= 6) chk("normal_no_bubble", seen_cyc[5] - seen_cyc[0], 5);
    chk("normal_seq_lit", seq_num, 1);
    chk("normal_errs_lit", {err_short, err_long}, 0);

    // short frame
    fw = '{32'h11, 32'h22, 32'h44};
    directed(32'd8, 3);
`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
    lit_d = '{32'hA5A50001, 32'd8, 32'h11, 32'h22, 32'h44, 32'h77};
    lit_l = '{0, 0, 0, 0, 0, 1};
`else
    lit_d = '{32'hA5A50001, 32'd8, 32'h11, 32'h22, 32'h44};
    lit_l = '{0, 0, 0, 0, 1};
`endif
    check_seen("short");
    chk("short_err_lit", err_short, 1);

    // long frame: excess beats accepted and dropped
    fw = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106};
    directed(32'd3, 6);
`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
    lit_d = '{32'hA5A50002, 32'd3, 32'h101, 32'h102, 32'h103, 32'h100};
    lit_l = '{0, 0, 0, 0, 0, 1};
`else
    lit_d = '{32'hA5A50002, 32'd3, 32'h101, 32'h102, 32'h103};
    lit_l = '{0, 0, 0, 0, 1};
`endif
    check_seen("long");
    chk("long_err_lit", err_long, 1);
    chk("long_idle_ready", s_tready, 0);

    // frame_size 0 behaves as 1
    fw = '{32'hABCD};
    directed(32'd0, 1);
`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
    lit_d = '{32'hA5A50003, 32'd1, 32'hABCD, 32'hABCD};
    lit_l = '{0, 0, 0, 1};
`else
    lit_d = '{32'hA5A50003, 32'd1, 32'hABCD};
    lit_l = '{0, 0, 1};
`endif
    check_seen("fs_zero");

`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
    fw = '{32'h0F0F0F0F, 32'hFFFF0000};
    directed(32'd2, 2);
    lit_d = '{32'hA5A50004, 32'd2, 32'h0F0F0F0F, 32'hFFFF0000, 32'hF0F00F0F};
    lit_l = '{0, 0, 0, 0, 1};
    check_seen("trailer");
`endif

    // alternating backpressure
    rdy_mode = 1;
    fw.delete();
    for (int i = 0; i < 16; i++) fw.push_back($urandom);
    directed(32'd16, 16);
`ifdef AXIS_FRAME_STAMPER_TRAILER_EN
    chk("bp_beats", seen.size(), 19);
`else
    chk("bp_beats", seen.size(), 18);
`endif
    chk_counters("bp");
    rdy_mode = 0;

    // reset during payload beat 2
    chk_en = 0;
    frame_size = 32'd4;
    s_tvalid = 1'b1; s_tdata = 32'hD1; s_tkeep = 4'hF; s_tlast = 1'b0;
    wait_accept();
    s_tdata = 32'hD2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_seq_num", seq_num, 0);
    chk("midrst_err_short", err_short, 0);
    chk("midrst_err_long", err_long, 0);
    chk("midrst_s_tready", s_tready, 0);
    reset = 1'b0;
    s_tvalid = 1'b0;
    exp_q.delete();
    seq_m = 0; short_m = 0; long_m = 0;
    @(posedge clk);
    #1;
    chk_en = 1;

    // randomized frames; enough of them to wrap seq_num and saturate error counters
    for (int f = 0; f < 320; f++) begin
      int          n;
      int          r;
      logic [31:0] fs;
      if (f % 40 == 0) rdy_mode = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r == 0)      fs = 32'd0;
      else if (r == 1) fs = 32'hFFFF_FFFF;
      else             fs = $urandom_range(1, 8);
      n = $urandom_range(1, 10);
      fw.delete();
      fk.delete();
      for (int i = 0; i < n; i++) begin
        fw.push_back($urandom);
        fk.push_back(4'($urandom));
      end
      send_frame(fs, n, 1);
      if (f % 40 == 39) begin
        wait_drain();
        chk_counters($sformatf("rand%0d", f));
      end
    end
    wait_drain();
    chk_counters("final");
    chk("final_seq_wrapped", seq_num, 320 % 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    timeout_fail("global");
  end
endmodule
